// File: rtl/spi_link_cmd_tx_if.sv
// Command, payload, SPI byte and response signals of the SPI link command transmitter.
// Every valid/ready pair transfers on a rising edge where both are 1; a source must not
// drop valid or change its data until that transfer happens, and ready may not wait on valid.
interface spi_link_cmd_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_len;

  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;

  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;

  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        busy;
  logic [2:0]  dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    output pl_data, pl_valid,
    output tx_ready, rx_byte, rx_valid,
    input  cmd_ready, pl_ready, tx_byte, tx_valid,
    input  rsp_data, rsp_valid, busy, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    input  pl_data, pl_valid,
    input  tx_ready, rx_byte, rx_valid,
    output cmd_ready, pl_ready, tx_byte, tx_valid,
    output rsp_data, rsp_valid, busy, dbg_state
  );
endinterface

// File: rtl/spi_link_cmd_tx.sv
// Turns register-write, stream and SD-access commands into SPI byte sequences,
// keeping exactly one byte in flight and returning the SD read byte.
module spi_link_cmd_tx #(
  parameter logic [7:0] OP_WR_REG  = 8'h87,
  parameter logic [7:0] OP_RX_DATA = 8'h88,
  parameter logic [7:0] OP_SD      = 8'h89
) (
  input logic              clk,
  input logic              rst,
  spi_link_cmd_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_RX = 3'd2,
    PAYLOAD = 3'd3,
    PL_WAIT = 3'd4,
    CAPTURE = 3'd5
  } state_e;

  localparam logic [1:0] OPC_WR_REG = 2'd0;
  localparam logic [1:0] OPC_STREAM = 2'd1;
  localparam logic [1:0] OPC_SD_RD  = 2'd2;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [6:0]  addr_q;
  logic [7:0]  data_q;
  logic [15:0] len_q;
  logic [1:0]  idx_q;
  logic [15:0] cnt_q;
  logic [7:0]  tx_byte_q;
  logic        tx_valid_q;
  logic        cmd_ready_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_valid_q;
  logic [1:0]  last_idx;

  // Header byte idx of a command: opcode, then the op-specific second and third bytes.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  op,
                                          input logic [1:0]  idx,
                                          input logic [6:0]  addr,
                                          input logic [7:0]  data,
                                          input logic [15:0] len);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: begin
        if (op == OPC_WR_REG)      b = OP_WR_REG;
        else if (op == OPC_STREAM) b = OP_RX_DATA;
        else                       b = OP_SD;
      end
      2'd1: begin
        case (op)
          2'd0:    b = data;
          2'd1:    b = len[7:0];
          2'd2:    b = {1'b0, addr};
          default: b = {1'b1, addr};
        endcase
      end
      default: begin
        case (op)
          2'd1:    b = len[15:8];
          2'd3:    b = data;
          default: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

  assign last_idx = (op_q == OPC_WR_REG) ? 2'd1 : 2'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      addr_q      <= 7'd0;
      data_q      <= 8'd0;
      len_q       <= 16'd0;
      idx_q       <= 2'd0;
      cnt_q       <= 16'd0;
      tx_byte_q   <= 8'd0;
      tx_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            addr_q      <= bus.cmd_addr;
            data_q      <= bus.cmd_data;
            len_q       <= bus.cmd_len;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            tx_byte_q   <= hdr_byte(bus.cmd_op, 2'd0, bus.cmd_addr, bus.cmd_data, bus.cmd_len);
            tx_valid_q  <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            // The SD read dummy byte is the one whose returned byte is kept.
            state_q    <= (op_q == OPC_SD_RD && idx_q == 2'd2) ? CAPTURE : WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (bus.rx_valid) begin
            if (idx_q == last_idx) begin
              if (op_q == OPC_STREAM) begin
                state_q <= PAYLOAD;
              end else begin
                state_q     <= IDLE;
                cmd_ready_q <= 1'b1;
              end
            end else begin
              idx_q      <= idx_q + 2'd1;
              tx_byte_q  <= hdr_byte(op_q, idx_q + 2'd1, addr_q, data_q, len_q);
              tx_valid_q <= 1'b1;
              state_q    <= SEND;
            end
          end
        end
        PAYLOAD: begin
          if (bus.pl_valid && bus.tx_ready) state_q <= PL_WAIT;
        end
        PL_WAIT: begin
          if (bus.rx_valid) begin
            // Compare before incrementing so len 16'hFFFF runs the full 65536 bytes.
            if (cnt_q == len_q) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + 16'd1;
              state_q <= PAYLOAD;
            end
          end
        end
        CAPTURE: begin
          if (bus.rx_valid) begin
            rsp_data_q  <= bus.rx_byte;
            rsp_valid_q <= 1'b1;
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          tx_valid_q  <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The payload streams straight through from the source to the SPI byte port.
  assign bus.tx_valid  = (state_q == PAYLOAD) ? bus.pl_valid : tx_valid_q;
  assign bus.tx_byte   = (state_q == PAYLOAD) ? bus.pl_data  : tx_byte_q;
  assign bus.pl_ready  = (state_q == PAYLOAD) & bus.tx_ready;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule
